// File: rtl/bus_master_q.sv
// CPU insn/data requests queue in per-channel FIFOs and issue onto two independent Avalon-MM hosts.
// Issue is one cycle after a push into an empty FIFO. *_req_ready drops while a FIFO is full.

module bus_master_q_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
  assign head_vld = (count != '0);
  assign full     = (count == CW'(DEPTH));
endmodule

module bus_master_q_chan #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] req_dat,
  input  logic         waitrequest,
  output logic         req_ready,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic         done,
  output logic         error
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic          full;
  logic          expire;
  logic [TW-1:0] stall_cnt;

  bus_master_q_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (start & ~full),
    .push_dat (req_dat),
    .pop      (done),
    .head_dat (head_dat),
    .head_vld (head_vld),
    .full     (full)
  );

  assign req_ready = ~full;
  // A stuck head is retired with an error on its TIMEOUT-th stalled cycle.
  assign expire    = (TIMEOUT > 0) && head_vld && waitrequest && (stall_cnt == TO_LAST);
  assign done      = head_vld & (~waitrequest | expire);
  assign error     = expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!head_vld || done) begin
      stall_cnt <= '0;
    end else if (waitrequest && (TIMEOUT > 0)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

module bus_master_q #(
  parameter int DATA_W  = 32,
  parameter int INSN_W  = 128,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              cpu_clk,
  output logic                              cpu_rst_n,
  output logic                              irq,
  input  logic                              avl_irq,
  input  logic                              insn_start,
  input  logic [32-$clog2(INSN_W/8)-1:0]    insn_addr,
  output logic                              insn_req_ready,
  output logic                              insn_ready,
  output logic                              insn_error,
  output logic [INSN_W-1:0]                 insn_data_rd,
  input  logic                              data_start,
  input  logic                              data_write,
  input  logic [32-$clog2(DATA_W/8)-1:0]    data_addr,
  input  logic [DATA_W-1:0]                 data_data_wr,
  input  logic [DATA_W/8-1:0]               data_data_be,
  output logic                              data_req_ready,
  output logic                              data_ready,
  output logic                              data_error,
  output logic [DATA_W-1:0]                 data_data_rd,
  output logic [31:0]                       avl_insn_address,
  output logic                              avl_insn_read,
  input  logic [INSN_W-1:0]                 avl_insn_readdata,
  input  logic                              avl_insn_waitrequest,
  output logic [31:0]                       avl_data_address,
  output logic                              avl_data_read,
  output logic                              avl_data_write,
  output logic [DATA_W-1:0]                 avl_data_writedata,
  output logic [DATA_W/8-1:0]               avl_data_byteenable,
  input  logic [DATA_W-1:0]                 avl_data_readdata,
  input  logic                              avl_data_waitrequest
);
  localparam int DLB = $clog2(DATA_W / 8);
  localparam int ILB = $clog2(INSN_W / 8);
  localparam int DAW = 32 - DLB;
  localparam int IAW = 32 - ILB;
  localparam int BEW = DATA_W / 8;
  localparam int DPW = 1 + DAW + DATA_W + BEW;

  assign cpu_clk   = clk;
  assign cpu_rst_n = rst_n;
  assign irq       = avl_irq;

  logic           i_vld, i_done, i_err;
  logic [IAW-1:0] i_addr;

  bus_master_q_chan #(.W(IAW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_insn (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (insn_start),
    .req_dat     (insn_addr),
    .waitrequest (avl_insn_waitrequest),
    .req_ready   (insn_req_ready),
    .head_vld    (i_vld),
    .head_dat    (i_addr),
    .done        (i_done),
    .error       (i_err)
  );

  assign avl_insn_read    = i_vld;
  assign avl_insn_address = i_vld ? (32'(i_addr) << ILB) : '0;
  assign insn_ready       = i_done;
  assign insn_error       = i_err;
  assign insn_data_rd     = (i_done & ~i_err) ? avl_insn_readdata : '0;

  logic              d_vld, d_done, d_err;
  logic [DPW-1:0]    d_head;
  logic              h_wr;
  logic [DAW-1:0]    h_addr;
  logic [DATA_W-1:0] h_wdat;
  logic [BEW-1:0]    h_be;

  bus_master_q_chan #(.W(DPW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_data (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (data_start),
    .req_dat     ({data_write, data_addr, data_data_wr, data_data_be}),
    .waitrequest (avl_data_waitrequest),
    .req_ready   (data_req_ready),
    .head_vld    (d_vld),
    .head_dat    (d_head),
    .done        (d_done),
    .error       (d_err)
  );

  assign {h_wr, h_addr, h_wdat, h_be} = d_head;

  // Command fields are gated by head valid so an empty queue presents an all-zero bus.
  assign avl_data_read       = d_vld & ~h_wr;
  assign avl_data_write      = d_vld & h_wr;
  assign avl_data_address    = d_vld ? (32'(h_addr) << DLB) : '0;
  assign avl_data_writedata  = d_vld ? h_wdat : '0;
  assign avl_data_byteenable = !d_vld ? '0 : (h_wr ? h_be : '1);
  assign data_ready          = d_done;
  assign data_error          = d_err;
  assign data_data_rd        = (d_done & ~d_err) ? avl_data_readdata : '0;
endmodule

// File: tb/tb_bus_master_q.sv
// Directed vector table for the data channel plus hand sequences for FIFO fill, timeout, reset and interleaved traffic.
module tb_bus_master_q;
  localparam int DATA_W = 32, INSN_W = 128, DEPTH = 4, TIMEOUT = 8;

  logic clk = 1'b0, rst_n = 1'b0, avl_irq = 1'b0;
  logic cpu_clk, cpu_rst_n, irq;
  logic insn_start = 1'b0;
  logic [27:0] insn_addr = '0;
  logic insn_req_ready, insn_ready, insn_error;
  logic [127:0] insn_data_rd;
  logic data_start = 1'b0, data_write = 1'b0;
  logic [29:0] data_addr = '0;
  logic [31:0] data_data_wr = '0;
  logic [3:0] data_data_be = '0;
  logic data_req_ready, data_ready, data_error;
  logic [31:0] data_data_rd;
  logic [31:0] avl_insn_address;
  logic avl_insn_read;
  logic [127:0] avl_insn_readdata = '0;
  logic avl_insn_waitrequest = 1'b0;
  logic [31:0] avl_data_address;
  logic avl_data_read, avl_data_write;
  logic [31:0] avl_data_writedata;
  logic [3:0] avl_data_byteenable;
  logic [31:0] avl_data_readdata = '0;
  logic avl_data_waitrequest = 1'b0;

  bus_master_q #(.DATA_W(DATA_W), .INSN_W(INSN_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .irq(irq), .avl_irq(avl_irq),
    .insn_start(insn_start), .insn_addr(insn_addr), .insn_req_ready(insn_req_ready),
    .insn_ready(insn_ready), .insn_error(insn_error), .insn_data_rd(insn_data_rd),
    .data_start(data_start), .data_write(data_write), .data_addr(data_addr),
    .data_data_wr(data_data_wr), .data_data_be(data_data_be), .data_req_ready(data_req_ready),
    .data_ready(data_ready), .data_error(data_error), .data_data_rd(data_data_rd),
    .avl_insn_address(avl_insn_address), .avl_insn_read(avl_insn_read),
    .avl_insn_readdata(avl_insn_readdata), .avl_insn_waitrequest(avl_insn_waitrequest),
    .avl_data_address(avl_data_address), .avl_data_read(avl_data_read),
    .avl_data_write(avl_data_write), .avl_data_writedata(avl_data_writedata),
    .avl_data_byteenable(avl_data_byteenable), .avl_data_readdata(avl_data_readdata),
    .avl_data_waitrequest(avl_data_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic start, wr; logic [29:0] addr; logic [31:0] wdat; logic [3:0] be; logic wreq; logic [31:0] rdat;
    logic x_rr, x_rd, x_wr; logic [31:0] x_addr, x_wdat; logic [3:0] x_be; logic x_rdy, x_err; logic [31:0] x_drd;
  } dvec_t;

  typedef struct packed { logic wr; logic [29:0] addr; logic [31:0] wdat; logic [3:0] be; } dreq_t;

  dvec_t tv [13];
  logic [27:0] iq [$];
  dreq_t dq [$];

  initial begin
    // inputs: start wr addr wdat be wreq rdat | expect: req_ready read write addr wdata be ready error data_rd
    tv[0]  = '{1'b0,1'b0,30'h0, 32'h0,4'h0,1'b0,32'h55AA55AA, 1'b1,1'b0,1'b0,32'h0, 32'h0,4'h0,1'b0,1'b0,32'h0};
    tv[1]  = '{1'b1,1'b0,30'h10,32'h0,4'h0,1'b0,32'h55AA55AA, 1'b1,1'b0,1'b0,32'h0, 32'h0,4'h0,1'b0,1'b0,32'h0};
    tv[2]  = '{1'b0,1'b0,30'h0, 32'h0,4'h0,1'b0,32'hDEADBEEF, 1'b1,1'b1,1'b0,32'h40,32'h0,4'hF,1'b1,1'b0,32'hDEADBEEF};
    tv[3]  = '{1'b1,1'b1,30'h20,32'h12345678,4'h3,1'b1,32'h0, 1'b1,1'b0,1'b0,32'h0, 32'h0,4'h0,1'b0,1'b0,32'h0};
    tv[4]  = '{1'b0,1'b0,30'h0, 32'h0,4'h0,1'b1,32'h99,       1'b1,1'b0,1'b1,32'h80,32'h12345678,4'h3,1'b0,1'b0,32'h0};
    tv[5]  = tv[4];
    tv[6]  = tv[4];
    tv[7]  = '{1'b0,1'b0,30'h0, 32'h0,4'h0,1'b0,32'h0,        1'b1,1'b0,1'b1,32'h80,32'h12345678,4'h3,1'b1,1'b0,32'h0};
    tv[8]  = '{1'b0,1'b0,30'h0, 32'h0,4'h0,1'b0,32'h77,       1'b1,1'b0,1'b0,32'h0, 32'h0,4'h0,1'b0,1'b0,32'h0};
    tv[9]  = '{1'b1,1'b0,30'h1, 32'h0,4'h0,1'b0,32'h77,       1'b1,1'b0,1'b0,32'h0, 32'h0,4'h0,1'b0,1'b0,32'h0};
    tv[10] = '{1'b1,1'b0,30'h2, 32'h0,4'h0,1'b0,32'h11111111, 1'b1,1'b1,1'b0,32'h4, 32'h0,4'hF,1'b1,1'b0,32'h11111111};
    tv[11] = '{1'b0,1'b0,30'h0, 32'h0,4'h0,1'b0,32'h22222222, 1'b1,1'b1,1'b0,32'h8, 32'h0,4'hF,1'b1,1'b0,32'h22222222};
    tv[12] = '{1'b0,1'b0,30'h0, 32'h0,4'h0,1'b0,32'h33,       1'b1,1'b0,1'b0,32'h0, 32'h0,4'h0,1'b0,1'b0,32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    avl_insn_readdata = '1;
    #2;
    chk("rst.insn_req_ready", insn_req_ready, 1'b1);
    chk("rst.insn_read", avl_insn_read, 1'b0);
    chk("rst.insn_address", avl_insn_address, 32'h0);
    chk("rst.insn_ready", insn_ready, 1'b0);
    chk("rst.insn_error", insn_error, 1'b0);
    chk("rst.insn_data_rd", insn_data_rd, 128'h0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      data_start = tv[i].start; data_write = tv[i].wr; data_addr = tv[i].addr;
      data_data_wr = tv[i].wdat; data_data_be = tv[i].be;
      avl_data_waitrequest = tv[i].wreq; avl_data_readdata = tv[i].rdat;
      #2;
      chk($sformatf("v%0d.req_ready", i), data_req_ready, tv[i].x_rr);
      chk($sformatf("v%0d.read", i), avl_data_read, tv[i].x_rd);
      chk($sformatf("v%0d.write", i), avl_data_write, tv[i].x_wr);
      chk($sformatf("v%0d.address", i), avl_data_address, tv[i].x_addr);
      chk($sformatf("v%0d.writedata", i), avl_data_writedata, tv[i].x_wdat);
      chk($sformatf("v%0d.byteenable", i), avl_data_byteenable, tv[i].x_be);
      chk($sformatf("v%0d.ready", i), data_ready, tv[i].x_rdy);
      chk($sformatf("v%0d.error", i), data_error, tv[i].x_err);
      chk($sformatf("v%0d.data_rd", i), data_data_rd, tv[i].x_drd);
    end

    // Insn FIFO fill: 5 starts under stall, 4 accepted, then drained in order.
    for (int c = 0; c < 10; c++) begin
      int cnt, head;
      @(negedge clk);
      data_start = 1'b0;
      insn_start = (c < 5);
      insn_addr = 28'(c + 1);
      avl_insn_waitrequest = (c < 5);
      avl_insn_readdata = {96'h0, 32'hA0000000 + 32'(c)};
      #2;
      cnt = (c <= 4) ? c : 9 - c;
      head = (c <= 5) ? 1 : c - 4;
      chk($sformatf("fill%0d.req_ready", c), insn_req_ready, cnt < DEPTH);
      chk($sformatf("fill%0d.read", c), avl_insn_read, cnt > 0);
      chk($sformatf("fill%0d.address", c), avl_insn_address, (cnt > 0) ? 32'(head) << 4 : 32'h0);
      chk($sformatf("fill%0d.ready", c), insn_ready, c >= 5 && c <= 8);
      chk($sformatf("fill%0d.error", c), insn_error, 1'b0);
      chk($sformatf("fill%0d.data_rd", c), insn_data_rd,
          (c >= 5 && c <= 8) ? {96'h0, 32'hA0000000 + 32'(c)} : 128'h0);
    end

    // Timeout: head stalls 8 cycles and is retired with error, queued request follows.
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      insn_start = 1'b0;
      data_start = (c < 2); data_write = 1'b0;
      data_addr = (c == 0) ? 30'h5 : 30'h6;
      avl_data_waitrequest = (c <= 8);
      avl_data_readdata = 32'hC0DE0000 + 32'(c);
      #2;
      chk($sformatf("to%0d.read", c), avl_data_read, c >= 1 && c <= 9);
      chk($sformatf("to%0d.address", c), avl_data_address,
          (c >= 1 && c <= 8) ? 32'h14 : (c == 9) ? 32'h18 : 32'h0);
      chk($sformatf("to%0d.ready", c), data_ready, c == 8 || c == 9);
      chk($sformatf("to%0d.error", c), data_error, c == 8);
      chk($sformatf("to%0d.data_rd", c), data_data_rd, (c == 9) ? 32'hC0DE0009 : 32'h0);
      chk($sformatf("to%0d.req_ready", c), data_req_ready, 1'b1);
    end

    // Reset while one request stalls and two are queued.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      data_start = (c < 3); data_write = 1'b0;
      data_addr = 30'h100 + 30'(c);
      avl_data_waitrequest = (c <= 3);
      avl_data_readdata = 32'hFEED0000 + 32'(c);
      rst_n = (c != 3);
      #2;
      if (c == 3) chk("rst3.read_before_edge", avl_data_read, 1'b1);
      if (c >= 4) begin
        chk($sformatf("rst%0d.read", c), avl_data_read, 1'b0);
        chk($sformatf("rst%0d.address", c), avl_data_address, 32'h0);
        chk($sformatf("rst%0d.ready", c), data_ready, 1'b0);
        chk($sformatf("rst%0d.req_ready", c), data_req_ready, 1'b1);
      end
    end

    // Interleaved traffic with independent random stalls against a reference queue model.
    begin
      int i_cnt = 0, d_cnt = 0;
      for (int c = 0; c < 200; c++) begin
        logic i_vld, i_exp, i_done, d_vld, d_exp, d_done, i_push, d_push;
        dreq_t h;
        @(negedge clk);
        insn_start = 1'(c < 180 && $urandom_range(0, 1) == 1);
        insn_addr = 28'($urandom);
        avl_insn_waitrequest = ($urandom_range(0, 2) == 0);
        avl_insn_readdata = {$urandom, $urandom, $urandom, $urandom};
        data_start = 1'(c < 180 && $urandom_range(0, 1) == 1);
        data_write = 1'($urandom_range(0, 1));
        data_addr = 30'($urandom);
        data_data_wr = $urandom;
        data_data_be = 4'($urandom);
        avl_data_waitrequest = ($urandom_range(0, 2) == 0);
        avl_data_readdata = $urandom;
        avl_irq = 1'($urandom_range(0, 1));
        #2;
        chk("mix.cpu_clk", cpu_clk, clk);
        chk("mix.cpu_rst_n", cpu_rst_n, rst_n);
        chk("mix.irq", irq, avl_irq);

        i_vld = (iq.size() > 0);
        i_exp = i_vld && avl_insn_waitrequest && (i_cnt == TIMEOUT - 1);
        i_done = i_vld && (!avl_insn_waitrequest || i_exp);
        chk($sformatf("mix%0d.insn_req_ready", c), insn_req_ready, iq.size() < DEPTH);
        chk($sformatf("mix%0d.insn_read", c), avl_insn_read, i_vld);
        chk($sformatf("mix%0d.insn_address", c), avl_insn_address, i_vld ? {iq[0], 4'b0} : 32'h0);
        chk($sformatf("mix%0d.insn_ready", c), insn_ready, i_done);
        chk($sformatf("mix%0d.insn_error", c), insn_error, i_exp);
        chk($sformatf("mix%0d.insn_data_rd", c), insn_data_rd, (i_done && !i_exp) ? avl_insn_readdata : 128'h0);
        i_push = insn_start && (iq.size() < DEPTH);
        if (i_done) begin void'(iq.pop_front()); i_cnt = 0; end
        else if (i_vld && avl_insn_waitrequest) i_cnt++;
        else i_cnt = 0;
        if (i_push) iq.push_back(insn_addr);

        d_vld = (dq.size() > 0);
        h = d_vld ? dq[0] : '0;
        d_exp = d_vld && avl_data_waitrequest && (d_cnt == TIMEOUT - 1);
        d_done = d_vld && (!avl_data_waitrequest || d_exp);
        chk($sformatf("mix%0d.data_req_ready", c), data_req_ready, dq.size() < DEPTH);
        chk($sformatf("mix%0d.data_read", c), avl_data_read, d_vld && !h.wr);
        chk($sformatf("mix%0d.data_write", c), avl_data_write, d_vld && h.wr);
        chk($sformatf("mix%0d.data_address", c), avl_data_address, d_vld ? {h.addr, 2'b0} : 32'h0);
        chk($sformatf("mix%0d.data_writedata", c), avl_data_writedata, d_vld ? h.wdat : 32'h0);
        chk($sformatf("mix%0d.data_be", c), avl_data_byteenable, !d_vld ? 4'h0 : (h.wr ? h.be : 4'hF));
        chk($sformatf("mix%0d.data_ready", c), data_ready, d_done);
        chk($sformatf("mix%0d.data_error", c), data_error, d_exp);
        chk($sformatf("mix%0d.data_rd", c), data_data_rd, (d_done && !d_exp) ? avl_data_readdata : 32'h0);
        d_push = data_start && (dq.size() < DEPTH);
        if (d_done) begin void'(dq.pop_front()); d_cnt = 0; end
        else if (d_vld && avl_data_waitrequest) d_cnt++;
        else d_cnt = 0;
        if (d_push) dq.push_back('{data_write, data_addr, data_data_wr, data_data_be});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
